// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage byte-lane formatter and the dcache write port.
// FIFO of word-aligned stores drained by req/ack; flags loads that hit a buffered word.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [3:0]        st_we,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  input  logic              fence,
  output logic              empty,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int WA = ADDR_W - 2;

  typedef struct packed {
    logic [WA-1:0] waddr;
    logic [3:0]    we;
    logic [31:0]   data;
  } sb_entry_t;

  typedef enum logic {RUN, DRAIN} state_t;

  sb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic          push, pop;
  sb_entry_t     head;
  logic [DEPTH-1:0] hit;

  assign empty    = (count_q == '0);
  assign mem_req  = ~empty;
  assign st_ready = (state_q == RUN) && (count_q < (PW+1)'(DEPTH)) && ~fence;
  assign push     = st_valid && (st_we != 4'b0000) && st_ready;
  assign pop      = mem_req && mem_ack;

  // Head fields are forced to zero while empty so the dcache never sees stale data.
  assign head      = ent_q[rd_ptr_q];
  assign mem_addr  = empty ? '0 : {head.waddr, 2'b00};
  assign mem_we    = empty ? '0 : head.we;
  assign mem_wdata = empty ? '0 : head.data;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Reaching empty always returns to RUN; that takes precedence over a fence entering DRAIN.
  always_comb begin
    state_d = state_q;
    if (count_d == '0)               state_d = RUN;
    else if (fence && !empty)        state_d = DRAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr_q] <= '{waddr: st_addr[ADDR_W-1:2], we: st_we, data: st_data};
  end

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PW-1:0] off;
    assign off    = PW'(i) - rd_ptr_q;
    assign hit[i] = ({1'b0, off} < count_q) && (ent_q[i].waddr == ld_addr[ADDR_W-1:2]);
  end

  assign ld_hazard = ld_valid && (|hit);

endmodule

// File: tb/tb_store_buffer.sv
// Directed + randomized bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              st_valid = 1'b0, ld_valid = 1'b0, fence = 1'b0, mem_ack = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0, ld_addr = '0;
  logic [3:0]        st_we = '0;
  logic [31:0]       st_data = '0;
  logic              st_ready, ld_hazard, empty, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_we(st_we), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .fence(fence), .empty(empty),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [3:0]  we;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   drain;
  int   tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: occupancy, head and hazard derived straight from the queue contents.
  task automatic check_all();
    bit          rdy, haz;
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    rdy = !drain && (q.size() < DEPTH) && !fence;
    haz = 1'b0;
    foreach (q[k]) if (ld_valid && q[k].wa == ld_addr[31:2]) haz = 1'b1;
    ea = '0; ew = '0; ed = '0;
    if (q.size() != 0) begin
      ea = {q[0].wa, 2'b00}; ew = q[0].we; ed = q[0].d;
    end
    chk("st_ready",  st_ready,  rdy);
    chk("empty",     empty,     q.size() == 0);
    chk("mem_req",   mem_req,   q.size() != 0);
    chk("mem_addr",  mem_addr,  ea);
    chk("mem_we",    mem_we,    ew);
    chk("mem_wdata", mem_wdata, ed);
    chk("ld_hazard", ld_hazard, haz);
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = !drain && (q.size() < DEPTH) && !fence;
    if (q.size() != 0 && mem_ack) void'(q.pop_front());
    if (st_valid && st_we != 4'b0000 && rdy) q.push_back('{st_addr[31:2], st_we, st_data});
    if (q.size() == 0) drain = 1'b0;
    else if (fence)    drain = 1'b1;
  endtask

  // Inputs change at posedge+1; outputs are checked at posedge+4.
  task automatic step();
    #3;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv(input bit sv, input logic [31:0] sa, input logic [3:0] we, input logic [31:0] sd,
                     input bit lv, input logic [31:0] la, input bit f, input bit ack);
    st_valid = sv; st_addr = sa; st_we = we; st_data = sd;
    ld_valid = lv; ld_addr = la; fence = f; mem_ack = ack;
  endtask

  initial begin
    drain = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_ready", st_ready, 1'b1);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 4'b0000);

    // Idle with ack asserted must not disturb the empty buffer.
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (10) step();

    // Single byte store.
    drv(1, 32'h103, 4'b1000, 32'hAB00_0000, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sb_req", mem_req, 1'b1);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_we", mem_we, 4'b1000);
    chk("sb_data", mem_wdata, 32'hAB00_0000);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("sb_empty", empty, 1'b1);

    // Fill to DEPTH, fifth push refused.
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'h300 + 4*i, 4'hF, 32'hC0DE_0000 + i, 0, 0, 0, 0);
      if (i == 4) chk("full_ready", st_ready, 1'b0);
      step();
    end
    drv(1, 32'h350, 4'hF, 32'h5555_0000, 0, 0, 0, 1);
    #1 chk("full_ready_ack", st_ready, 1'b0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    chk("drain0", mem_addr, 32'h304);
    step();
    chk("drain1", mem_addr, 32'h308);
    drv(1, 32'h340, 4'h3, 32'h0000_BEEF, 0, 0, 0, 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    chk("pp_addr", mem_addr, 32'h30C);
    chk("pp_empty", empty, 1'b0);
    step();
    chk("drain3", mem_addr, 32'h340);
    chk("drain3_data", mem_wdata, 32'h0000_BEEF);
    step();
    chk("drain_done", empty, 1'b1);

    // Load hazard.
    drv(1, 32'h200, 4'hF, 32'h1234_5678, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 1, 32'h202, 0, 0);
    #1 chk("haz_hit", ld_hazard, 1'b1);
    step();
    drv(0, 0, 0, 0, 1, 32'h204, 0, 0);
    #1 chk("haz_miss", ld_hazard, 1'b0);
    step();
    drv(0, 0, 0, 0, 1, 32'h202, 0, 1);
    #1 chk("haz_inflight", ld_hazard, 1'b1);
    step();
    drv(0, 0, 0, 0, 1, 32'h202, 0, 0);
    #1 chk("haz_gone", ld_hazard, 1'b0);
    step();

    // Fence drain.
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h400 + 4*i, 4'hF, 32'hF00D_0000 + i, 0, 0, 0, 0);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("fence_ready", st_ready, 1'b0);
    step();
    drv(1, 32'h500, 4'hF, 32'hDEAD_0000, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("fence_hold", st_ready, 1'b0);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fence_run", st_ready, 1'b1);
    chk("fence_empty", empty, 1'b1);
    step();

    // Randomized traffic over a small address pool so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      bit sv;
      sv = ($urandom_range(0, 2) != 0);
      drv(sv,
          32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3),
          ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
          $urandom,
          !sv && ($urandom_range(0, 1) == 1),
          32'h1000 + ($urandom_range(0, 9) << 2) + $urandom_range(0, 3),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 1) == 1));
      step();
    end

    // Async reset mid-drain.
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    while (q.size() != 0) step();
    for (int i = 0; i < 2; i++) begin
      drv(1, 32'h600 + 4*i, 4'hF, 32'hAAAA_0000 + i, 0, 0, 0, 0);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_req", mem_req, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_ready", st_ready, 1'b1);
    chk("arst_addr", mem_addr, 32'h0);
    q.delete();
    drain = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
